// File: rtl/ram_arb_defs.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ram_arb_defs: shared state encodings for the RAM arbiter   rev 1.0 |
// +--------------------------------------------------------------------+
package ram_arb_defs;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_picker: combinational round-robin winner select         rev 1.0 |
// +--------------------------------------------------------------------+
module rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last_grant,
  output logic               o_grant_valid,
  output logic [IDX_W-1:0]   o_grant_idx
);

  int w_dist;
  int w_best;

  // Distance 0 is the port right after the last grant; the smallest distance wins.
  always_comb begin
    o_grant_valid = 1'b0;
    o_grant_idx   = '0;
    w_best        = NUM_REQ;
    w_dist        = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_dist = (k + NUM_REQ - 1 - int'(i_last_grant)) % NUM_REQ;
      if (i_req[k] && (w_dist < w_best)) begin
        w_best        = w_dist;
        o_grant_valid = 1'b1;
        o_grant_idx   = IDX_W'(k);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ram_arbiter: round-robin share of a single-port data RAM   rev 1.0 |
// +--------------------------------------------------------------------+
module ram_arbiter
  import ram_arb_defs::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int MEM_DEPTH = 32
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ-1:0]        i_we,
  input  logic [NUM_REQ*ADDR_W-1:0] i_addr,
  input  logic [NUM_REQ*DATA_W-1:0] i_wdata,
  output logic [NUM_REQ-1:0]        o_ack,
  output logic [NUM_REQ-1:0]        o_err,
  output logic [NUM_REQ*DATA_W-1:0] o_rdata,
  output logic                      o_busy,
  output logic                      o_mem_read_en,
  output logic                      o_mem_write_en,
  output logic [ADDR_W-1:0]         o_mem_address,
  output logic [DATA_W-1:0]         o_mem_data_in,
  input  logic [DATA_W-1:0]         i_mem_out
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             r_state;
  state_t             w_next_state;
  logic [IDX_W-1:0]   r_last_grant;
  logic [IDX_W-1:0]   r_idx;
  logic               r_we;
  logic [NUM_REQ-1:0] r_ack;
  logic [NUM_REQ-1:0] r_err;
  logic               r_mem_re;
  logic               r_mem_we;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [DATA_W-1:0]  r_mem_din;
  logic [DATA_W-1:0]  r_rdata [NUM_REQ];

  logic               w_grant_valid;
  logic [IDX_W-1:0]   w_grant_idx;
  logic [ADDR_W-1:0]  w_addr  [NUM_REQ];
  logic [DATA_W-1:0]  w_wdata [NUM_REQ];
  logic [ADDR_W-1:0]  w_sel_addr;
  logic               w_in_range;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_port
    assign w_addr[k]                   = i_addr[k*ADDR_W +: ADDR_W];
    assign w_wdata[k]                  = i_wdata[k*DATA_W +: DATA_W];
    assign o_rdata[k*DATA_W +: DATA_W] = r_rdata[k];
  end

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .i_req         (i_req),
    .i_last_grant  (r_last_grant),
    .o_grant_valid (w_grant_valid),
    .o_grant_idx   (w_grant_idx)
  );

  assign w_sel_addr = w_addr[w_grant_idx];
  assign w_in_range = (w_sel_addr < ADDR_W'(MEM_DEPTH));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_grant_valid) w_next_state = w_in_range ? S_ISSUE : S_RESP;
      S_ISSUE: w_next_state = S_DONE;
      S_DONE:  w_next_state = S_RESP;
      S_RESP:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last_grant <= IDX_W'(NUM_REQ - 1);
      r_idx        <= '0;
      r_we         <= 1'b0;
      r_ack        <= '0;
      r_err        <= '0;
      r_mem_re     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_din    <= '0;
      for (int k = 0; k < NUM_REQ; k++) r_rdata[k] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_valid) begin
            r_idx        <= w_grant_idx;
            r_we         <= i_we[w_grant_idx];
            r_last_grant <= w_grant_idx;
            if (w_in_range) begin
              r_mem_addr <= w_sel_addr;
              r_mem_din  <= w_wdata[w_grant_idx];
              r_mem_we   <= i_we[w_grant_idx];
              r_mem_re   <= ~i_we[w_grant_idx];
            end else begin
              r_err[w_grant_idx]   <= 1'b1;
              r_ack[w_grant_idx]   <= 1'b1;
              r_rdata[w_grant_idx] <= '0;
            end
          end
        end
        S_ISSUE: begin
          r_mem_re <= 1'b0;
          r_mem_we <= 1'b0;
        end
        S_DONE: begin
          // A write reports the data it stored rather than depending on RAM read-during-write behaviour.
          r_rdata[r_idx] <= r_we ? r_mem_din : i_mem_out;
          r_ack[r_idx]   <= 1'b1;
        end
        S_RESP: begin
          r_ack <= '0;
          r_err <= '0;
        end
        default: begin
          r_ack <= '0;
          r_err <= '0;
        end
      endcase
    end
  end

  assign o_ack          = r_ack;
  assign o_err          = r_err;
  assign o_busy         = (r_state != S_IDLE);
  assign o_mem_read_en  = r_mem_re;
  assign o_mem_write_en = r_mem_we;
  assign o_mem_address  = r_mem_addr;
  assign o_mem_data_in  = r_mem_din;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_ram_arbiter: directed + random checks of ram_arbiter    rev 1.0 |
// +--------------------------------------------------------------------+
module tb_ram_arbiter;

  localparam int NR    = 2;
  localparam int AW    = 64;
  localparam int DW    = 64;
  localparam int DEPTH = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NR-1:0]    req = '0;
  logic [NR-1:0]    we  = '0;
  logic [NR*AW-1:0] addr  = '0;
  logic [NR*DW-1:0] wdata = '0;
  logic [NR-1:0]    ack;
  logic [NR-1:0]    err;
  logic [NR*DW-1:0] rdata;
  logic             busy;
  logic             mre;
  logic             mwe;
  logic [AW-1:0]    maddr;
  logic [DW-1:0]    mdin;
  logic [DW-1:0]    mem_out;

  logic [DW-1:0] ram     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  int last_served;
  int checks = 0;
  int errors = 0;

  bit            t_we   [NR];
  logic [AW-1:0] t_addr [NR];
  logic [DW-1:0] t_data [NR];
  bit            t_drop [NR];

  ram_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_addr(addr), .i_wdata(wdata),
    .o_ack(ack), .o_err(err), .o_rdata(rdata), .o_busy(busy),
    .o_mem_read_en(mre), .o_mem_write_en(mwe), .o_mem_address(maddr),
    .o_mem_data_in(mdin), .i_mem_out(mem_out)
  );

  always #5 clk = ~clk;

  // Registered single-port RAM, write-first.
  always @(posedge clk) begin
    if (mwe) begin
      ram[maddr[4:0]] <= mdin;
      mem_out         <= mdin;
    end else if (mre) begin
      mem_out <= ram[maddr[4:0]];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"},   64'(ack), 64'd0);
    chk({tag, "_err"},   64'(err), 64'd0);
    chk({tag, "_busy"},  64'(busy), 64'd0);
    chk({tag, "_mre"},   64'(mre), 64'd0);
    chk({tag, "_mwe"},   64'(mwe), 64'd0);
    chk({tag, "_maddr"}, maddr, 64'd0);
    chk({tag, "_mdin"},  mdin, 64'd0);
    chk({tag, "_rd0"},   rdata[63:0], 64'd0);
    chk({tag, "_rd1"},   rdata[127:64], 64'd0);
  endtask

  // Issue the requests flagged in act, predict order/latency/data from the rules, and compare.
  task automatic serve(input string tag, input bit [NR-1:0] act);
    int            first, tnow, n_mem, n_en, n_both, n_stray, cyc, p;
    int            exp_t [NR];
    int            got_t [NR];
    bit            exp_err [NR];
    bit            got_err [NR];
    logic [DW-1:0] exp_rd [NR];
    logic [DW-1:0] got_rd [NR];
    logic [DW-1:0] keep [NR];
    first = (act == 2'b11) ? (last_served + 1) % NR : (act[0] ? 0 : 1);
    tnow  = 0;
    n_mem = 0;
    for (int j = 0; j < NR; j++) begin
      p = (first + j) % NR;
      if (act[p]) begin
        if (t_addr[p] < DEPTH) begin
          exp_t[p]   = tnow + 3;
          exp_err[p] = 1'b0;
          exp_rd[p]  = t_we[p] ? t_data[p] : ref_mem[t_addr[p][4:0]];
          if (t_we[p]) ref_mem[t_addr[p][4:0]] = t_data[p];
          n_mem++;
          tnow += 4;
        end else begin
          exp_t[p]   = tnow + 1;
          exp_err[p] = 1'b1;
          exp_rd[p]  = '0;
          tnow += 2;
        end
        last_served = p;
      end
    end
    for (int k = 0; k < NR; k++) begin
      keep[k]  = rdata[k*DW +: DW];
      got_t[k] = -1;
      got_err[k] = 1'b0;
      got_rd[k]  = '0;
      if (act[k]) begin
        req[k]             = 1'b1;
        we[k]              = t_we[k];
        addr[k*AW +: AW]   = t_addr[k];
        wdata[k*DW +: DW]  = t_data[k];
      end
    end
    n_en = 0; n_both = 0; n_stray = 0; cyc = 0;
    while (((act[0] && got_t[0] < 0) || (act[1] && got_t[1] < 0)) && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
      if (mre || mwe) n_en++;
      if (mre && mwe) n_both++;
      for (int k = 0; k < NR; k++) begin
        if (ack[k]) begin
          if (!act[k] || got_t[k] >= 0) n_stray++;
          got_t[k]   = cyc;
          got_err[k] = err[k];
          got_rd[k]  = rdata[k*DW +: DW];
          req[k]     = 1'b0;
        end else if (err[k]) begin
          n_stray++;
        end
        if (t_drop[k] && act[k] && cyc == 1) req[k] = 1'b0;
      end
    end
    @(posedge clk); #1;
    chk({tag, "_idle_after"}, 64'(busy), 64'd0);
    for (int k = 0; k < NR; k++) begin
      if (act[k]) begin
        chk($sformatf("%s_ack_cycle_p%0d", tag, k), 64'(got_t[k]), 64'(exp_t[k]));
        chk($sformatf("%s_err_p%0d", tag, k), 64'(got_err[k]), 64'(exp_err[k]));
        chk($sformatf("%s_rdata_p%0d", tag, k), got_rd[k], exp_rd[k]);
      end else begin
        chk($sformatf("%s_rdata_hold_p%0d", tag, k), rdata[k*DW +: DW], keep[k]);
      end
      t_drop[k] = 1'b0;
    end
    chk({tag, "_mem_enable_cycles"}, 64'(n_en), 64'(n_mem));
    chk({tag, "_both_enables"}, 64'(n_both), 64'd0);
    chk({tag, "_stray_ack_err"}, 64'(n_stray), 64'd0);
  endtask

  initial begin
    int cyc, nacks, p, exp_p;
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]     = {$urandom, $urandom};
      ref_mem[i] = ram[i];
    end
    mem_out = '0;
    for (int k = 0; k < NR; k++) t_drop[k] = 1'b0;
    last_served = NR - 1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;

    // Port 0 writes, port 1 reads the same word back
    t_we[0] = 1'b1; t_addr[0] = 64'd5; t_data[0] = 64'h00000000DEADBEEF;
    serve("wr5_p0", 2'b01);
    t_we[1] = 1'b0; t_addr[1] = 64'd5; t_data[1] = '0;
    serve("rd5_p1", 2'b10);

    // Out-of-range read
    t_we[1] = 1'b0; t_addr[1] = 64'd40;
    serve("oor40_p1", 2'b10);
    t_we[0] = 1'b1; t_addr[0] = 64'd32; t_data[0] = 64'h1234;
    serve("oor32_p0", 2'b01);
    t_we[1] = 1'b0; t_addr[1] = 64'd31;
    serve("rd31_p1", 2'b10);

    // Port 0 drops req right after grant
    t_we[0] = 1'b0; t_addr[0] = 64'd9; t_drop[0] = 1'b1;
    serve("drop_p0", 2'b01);

    // Both ports hold req continuously: alternating grants every 4 cycles
    req = 2'b11; we = 2'b00;
    addr[0 +: AW] = 64'd1; addr[AW +: AW] = 64'd2;
    exp_p = (last_served + 1) % NR;
    nacks = 0; cyc = 0;
    while (nacks < 4 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (ack != 2'b00) begin
        p = ack[1] ? 1 : 0;
        chk($sformatf("cont_grant_%0d", nacks), 64'(p), 64'(exp_p));
        chk($sformatf("cont_ack_cycle_%0d", nacks), 64'(cyc), 64'(3 + 4 * nacks));
        chk($sformatf("cont_rdata_%0d", nacks), rdata[p*DW +: DW], ref_mem[exp_p + 1]);
        last_served = exp_p;
        exp_p = (exp_p + 1) % NR;
        nacks++;
        if (nacks == 4) req = 2'b00;
      end
    end
    chk("cont_ack_count", 64'(nacks), 64'd4);
    @(posedge clk); #1;

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      for (int k = 0; k < NR; k++) begin
        t_we[k]   = $urandom_range(0, 1) == 1;
        t_addr[k] = ($urandom_range(0, 7) == 0) ? 64'(32 + $urandom_range(0, 200))
                                                : 64'($urandom_range(0, 31));
        t_data[k] = {$urandom, $urandom};
      end
      serve($sformatf("rand%0d", it), 2'($urandom_range(1, 3)));
    end

    // Reset in the middle of an ISSUE cycle of a write
    req[0] = 1'b1; we[0] = 1'b1; addr[0 +: AW] = 64'd3; wdata[0 +: DW] = 64'h55;
    @(posedge clk); #1;
    chk("rst_mid_issue_we", 64'(mwe), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk_all_zero("rst_mid");
    req = 2'b00;
    @(posedge clk); #1;
    chk_all_zero("rst_held");
    rst = 1'b0;
    last_served = NR - 1;
    cyc = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ack != 2'b00) cyc++;
    end
    chk("rst_no_ack", 64'(cyc), 64'd0);
    t_we[0] = 1'b0; t_addr[0] = 64'd3;
    t_we[1] = 1'b0; t_addr[1] = 64'd7;
    serve("post_rst", 2'b11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
